peak_meter: RTL and testbench



---
 rtl/peak_meter_pkg.sv | 40 ++++
 rtl/peak_level_quant.sv | 35 +++
 rtl/peak_meter.sv | 210 +++++++++++++++++++++
 tb/tb_peak_meter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/peak_meter_pkg.sv
// -----------------------------------------------------------------------------
// peak_meter_pkg
// Shared definitions for the LED peak meter and its level quantiser.
//   - hold_state_t : encoding of the peak-hold dot state machine
//   - clog2        : ceil(log2(n)), usable in constant expressions
//   - cnt_width    : counter width for a terminal count (never below 1 bit)
//   - LVL_W / HOLD_CNT_W / DECAY_CNT_W : widths for the default build
//     (8 LEDs, 16 hold updates, 2 decay updates)
// -----------------------------------------------------------------------------
package peak_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FALL = 2'd2
  } hold_state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int p = 1; p < value; p = p * 2) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int cnt_width(input int terminal);
    return (clog2(terminal) < 1) ? 1 : clog2(terminal);
  endfunction

  localparam int DEF_BUS_WIDTH     = 12;
  localparam int DEF_NUM_LEDS      = 8;
  localparam int DEF_HOLD_UPDATES  = 16;
  localparam int DEF_DECAY_UPDATES = 2;

  localparam int LVL_W       = clog2(DEF_NUM_LEDS) + 1;
  localparam int HOLD_CNT_W  = cnt_width(DEF_HOLD_UPDATES);
  localparam int DECAY_CNT_W = cnt_width(DEF_DECAY_UPDATES);

endpackage

// File: rtl/peak_level_quant.sv
// -----------------------------------------------------------------------------
// peak_level_quant
// Combinational quantiser: maps a peak word to an LED level 0..NUM_LEDS.
// Zero maps to level 0; any non-zero word maps to its top log2(NUM_LEDS)
// bits plus one, so the smallest non-zero peak still lights one LED.
// Ports:
//   i_peak [BUS_WIDTH-1:0]  peak word
//   o_lvl  [LVL_WIDTH-1:0]  quantised level
// -----------------------------------------------------------------------------
module peak_level_quant
  import peak_meter_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  localparam int LOG2_LEDS = clog2(NUM_LEDS),
  localparam int LVL_WIDTH = LOG2_LEDS + 1
) (
  input  logic [BUS_WIDTH-1:0] i_peak,
  output logic [LVL_WIDTH-1:0] o_lvl
);

  localparam logic [LVL_WIDTH-1:0] LVL_ONE = LVL_WIDTH'(1);

  logic [LOG2_LEDS-1:0] w_top;

  assign w_top = i_peak[BUS_WIDTH-1 -: LOG2_LEDS];

  always_comb begin
    o_lvl = '0;
    if (i_peak != '0) begin
      o_lvl = {1'b0, w_top} + LVL_ONE;
    end
  end

endmodule

// File: rtl/peak_meter.sv
// -----------------------------------------------------------------------------
// peak_meter
// LED bar-graph level meter fed by the ADC peak detector. Each valid peak is
// quantised to a level; the bar jumps up instantly and decays one LED every
// DECAY_UPDATES strobes, while a single hold dot stays put for HOLD_UPDATES
// strobes and then falls one LED per strobe (never below the bar).
// State only advances on strobes; all outputs are registered.
// Optional build macro: PEAK_METER_CLIP_EN enables the clip indicator;
// without it clip_out is tied low.
// Ports:
//   dclk        sample clock, rising edge
//   rst         synchronous active-high reset (wins over peak_valid)
//   peak_in     peak word, sampled when peak_valid=1
//   peak_valid  one-cycle strobe for a new peak
//   bar_out     thermometer bar, bit k set iff k < bar level
//   hold_out    one-hot hold dot at bit (hold level - 1), zero at level 0
//   level_out   current bar level in binary
//   clip_out    clip indicator (0 unless PEAK_METER_CLIP_EN)
// -----------------------------------------------------------------------------
module peak_meter
  import peak_meter_pkg::*;
#(
  parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
  parameter int NUM_LEDS      = DEF_NUM_LEDS,
  parameter int HOLD_UPDATES  = DEF_HOLD_UPDATES,
  parameter int DECAY_UPDATES = DEF_DECAY_UPDATES,
  localparam int LVL_WIDTH    = clog2(NUM_LEDS) + 1
) (
  input  logic                 dclk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] peak_in,
  input  logic                 peak_valid,
  output logic [NUM_LEDS-1:0]  bar_out,
  output logic [NUM_LEDS-1:0]  hold_out,
  output logic [LVL_WIDTH-1:0] level_out,
  output logic                 clip_out
);

  localparam int HCW = cnt_width(HOLD_UPDATES);
  localparam int DCW = cnt_width(DECAY_UPDATES);

  localparam logic [HCW-1:0]       HOLD_LAST  = HCW'(HOLD_UPDATES - 1);
  localparam logic [DCW-1:0]       DECAY_LAST = DCW'(DECAY_UPDATES - 1);
  localparam logic [HCW-1:0]       HCNT_ONE   = HCW'(1);
  localparam logic [DCW-1:0]       DCNT_ONE   = DCW'(1);
  localparam logic [LVL_WIDTH-1:0] LVL_ONE    = LVL_WIDTH'(1);

  // State registers
  logic [LVL_WIDTH-1:0] r_bar_level;
  logic [LVL_WIDTH-1:0] r_hold_level;
  logic [DCW-1:0]       r_decay_cnt;
  logic [HCW-1:0]       r_hold_cnt;
  hold_state_t          r_state;
  logic [NUM_LEDS-1:0]  r_bar_out;
  logic [NUM_LEDS-1:0]  r_hold_out;

  // Next-state wires
  logic [LVL_WIDTH-1:0] w_new_lvl;
  logic [LVL_WIDTH-1:0] w_bar_next;
  logic [LVL_WIDTH-1:0] w_bar_dec;
  logic [DCW-1:0]       w_decay_next;
  logic [LVL_WIDTH-1:0] w_hold_next;
  logic [LVL_WIDTH-1:0] w_hold_dec;
  logic [LVL_WIDTH-1:0] w_fall_lvl;
  logic [HCW-1:0]       w_hold_cnt_next;
  hold_state_t          w_state_next;
  logic [NUM_LEDS-1:0]  w_bar_therm;
  logic [NUM_LEDS-1:0]  w_hold_onehot;

  peak_level_quant #(
    .BUS_WIDTH (BUS_WIDTH),
    .NUM_LEDS  (NUM_LEDS)
  ) u_quant (
    .i_peak (peak_in),
    .o_lvl  (w_new_lvl)
  );

  // ---------------------------------------------------------------------------
  // Bar: instant attack, stepped decay. The decay path only runs when the new
  // level is below the bar, so the bar is at least 1 and cannot underflow.
  // ---------------------------------------------------------------------------
  assign w_bar_dec = (r_bar_level != '0) ? (r_bar_level - LVL_ONE) : '0;

  always_comb begin
    w_bar_next   = r_bar_level;
    w_decay_next = r_decay_cnt;
    if (w_new_lvl >= r_bar_level) begin
      w_bar_next   = w_new_lvl;
      w_decay_next = '0;
    end else if (r_decay_cnt == DECAY_LAST) begin
      w_bar_next   = (w_bar_dec > w_new_lvl) ? w_bar_dec : w_new_lvl;
      w_decay_next = '0;
    end else begin
      w_decay_next = r_decay_cnt + DCNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold dot FSM. A new level at or above the dot always re-arms the hold,
  // whatever the current state. While falling, the dot is clamped to the
  // bar value produced by this same update so it never drops below the bar.
  // ---------------------------------------------------------------------------
  assign w_hold_dec = (r_hold_level != '0) ? (r_hold_level - LVL_ONE) : '0;
  assign w_fall_lvl = (w_hold_dec > w_bar_next) ? w_hold_dec : w_bar_next;

  always_comb begin
    w_state_next    = r_state;
    w_hold_next     = r_hold_level;
    w_hold_cnt_next = r_hold_cnt;
    if ((w_new_lvl != '0) && (w_new_lvl >= r_hold_level)) begin
      w_hold_next     = w_new_lvl;
      w_hold_cnt_next = '0;
      w_state_next    = HOLD;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = IDLE;
        end
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_hold_cnt_next = '0;
            w_state_next    = FALL;
          end else begin
            w_hold_cnt_next = r_hold_cnt + HCNT_ONE;
          end
        end
        FALL: begin
          w_hold_next = w_fall_lvl;
          if (w_fall_lvl == '0) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next    = IDLE;
          w_hold_next     = '0;
          w_hold_cnt_next = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // LED decode of the next levels, registered together with the state so the
  // pins change on the same edge as the levels.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi = gi + 1) begin : g_led
      assign w_bar_therm[gi]   = (LVL_WIDTH'(gi) < w_bar_next);
      assign w_hold_onehot[gi] = (w_hold_next == LVL_WIDTH'(gi + 1));
    end
  endgenerate

  always_ff @(posedge dclk) begin
    if (rst) begin
      r_bar_level  <= '0;
      r_hold_level <= '0;
      r_decay_cnt  <= '0;
      r_hold_cnt   <= '0;
      r_state      <= IDLE;
      r_bar_out    <= '0;
      r_hold_out   <= '0;
    end else if (peak_valid) begin
      r_bar_level  <= w_bar_next;
      r_hold_level <= w_hold_next;
      r_decay_cnt  <= w_decay_next;
      r_hold_cnt   <= w_hold_cnt_next;
      r_state      <= w_state_next;
      r_bar_out    <= w_bar_therm;
      r_hold_out   <= w_hold_onehot;
    end
  end

  assign bar_out   = r_bar_out;
  assign hold_out  = r_hold_out;
  assign level_out = r_bar_level;

  // ---------------------------------------------------------------------------
  // Clip indicator: set by a full-scale strobe, cleared after HOLD_UPDATES
  // consecutive strobes below full scale. A full-scale strobe restarts it.
  // ---------------------------------------------------------------------------
`ifdef PEAK_METER_CLIP_EN
  logic           r_clip;
  logic [HCW-1:0] r_clip_cnt;

  always_ff @(posedge dclk) begin
    if (rst) begin
      r_clip     <= 1'b0;
      r_clip_cnt <= '0;
    end else if (peak_valid) begin
      if (&peak_in) begin
        r_clip     <= 1'b1;
        r_clip_cnt <= '0;
      end else if (r_clip) begin
        if (r_clip_cnt == HOLD_LAST) begin
          r_clip     <= 1'b0;
          r_clip_cnt <= '0;
        end else begin
          r_clip_cnt <= r_clip_cnt + HCNT_ONE;
        end
      end
    end
  end

  assign clip_out = r_clip;
`else
  assign clip_out = 1'b0;
`endif

endmodule

// File: tb/tb_peak_meter.sv
// -----------------------------------------------------------------------------
// tb_peak_meter
// Scoreboard bench for peak_meter. The stimulus process drives inputs on the
// falling edge, advances a behavioural model of the meter and queues the
// expected outputs for the following rising edge. A monitor pops one entry
// after every rising edge and compares. Build with +define+PEAK_METER_CLIP_EN
// to also check the clip indicator.
// -----------------------------------------------------------------------------
module tb_peak_meter;

  localparam int BUS_WIDTH     = 12;
  localparam int NUM_LEDS      = 8;
  localparam int HOLD_UPDATES  = 16;
  localparam int DECAY_UPDATES = 2;
  localparam int LVL_WIDTH     = 4;
  localparam int FULL_SCALE    = (1 << BUS_WIDTH) - 1;

  logic                 dclk = 1'b0;
  logic                 rst = 1'b1;
  logic [BUS_WIDTH-1:0] peak_in = '0;
  logic                 peak_valid = 1'b0;
  logic [NUM_LEDS-1:0]  bar_out;
  logic [NUM_LEDS-1:0]  hold_out;
  logic [LVL_WIDTH-1:0] level_out;
  logic                 clip_out;

  peak_meter #(
    .BUS_WIDTH     (BUS_WIDTH),
    .NUM_LEDS      (NUM_LEDS),
    .HOLD_UPDATES  (HOLD_UPDATES),
    .DECAY_UPDATES (DECAY_UPDATES)
  ) dut (
    .dclk       (dclk),
    .rst        (rst),
    .peak_in    (peak_in),
    .peak_valid (peak_valid),
    .bar_out    (bar_out),
    .hold_out   (hold_out),
    .level_out  (level_out),
    .clip_out   (clip_out)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    int bar;
    int hold;
    int lvl;
    int clip;
    int st;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Behavioural model: levels as plain integers, dot phase as 0=idle,
  // 1=holding, 2=falling.
  int m_bar   = 0;
  int m_hold  = 0;
  int m_dcnt  = 0;
  int m_hcnt  = 0;
  int m_phase = 0;
  int m_since_fs = HOLD_UPDATES;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int quant(input int p);
    if (p == 0) return 0;
    return p / ((1 << BUS_WIDTH) / NUM_LEDS) + 1;
  endfunction

  task automatic model_update(input logic r, input logic v, input int p);
    int nl;
    if (r) begin
      m_bar = 0; m_hold = 0; m_dcnt = 0; m_hcnt = 0; m_phase = 0;
      m_since_fs = HOLD_UPDATES;
    end else if (v) begin
      nl = quant(p);
      if (nl >= m_bar) begin
        m_bar  = nl;
        m_dcnt = 0;
      end else begin
        m_dcnt = m_dcnt + 1;
        if (m_dcnt == DECAY_UPDATES) begin
          m_dcnt = 0;
          m_bar  = imax(m_bar - 1, nl);
        end
      end
      if (nl > 0 && nl >= m_hold) begin
        m_hold = nl; m_hcnt = 0; m_phase = 1;
      end else if (m_phase == 1) begin
        m_hcnt = m_hcnt + 1;
        if (m_hcnt == HOLD_UPDATES) begin
          m_hcnt = 0; m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_hold = imax(m_hold - 1, m_bar);
        if (m_hold == 0) m_phase = 0;
      end
      if (p == FULL_SCALE) m_since_fs = 0;
      else if (m_since_fs < HOLD_UPDATES) m_since_fs = m_since_fs + 1;
    end
  endtask

  task automatic step(input logic r, input logic v, input int p);
    exp_t e;
    @(negedge dclk);
    rst        = r;
    peak_valid = v;
    peak_in    = BUS_WIDTH'(p);
    model_update(r, v, p);
    e.bar  = (1 << m_bar) - 1;
    e.hold = (m_hold == 0) ? 0 : (1 << (m_hold - 1));
    e.lvl  = m_bar;
`ifdef PEAK_METER_CLIP_EN
    e.clip = (m_since_fs < HOLD_UPDATES) ? 1 : 0;
`else
    e.clip = 0;
`endif
    e.st   = m_phase;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int expv);
    checks = checks + 1;
    if (act != expv) begin
      failures = failures + 1;
      $display("FAIL %s txn=%0d got=%0h expected=%0h", name, txn, act, expv);
    end
  endtask

  function automatic int rand_peak();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return FULL_SCALE;
      default: return int'($urandom_range(0, FULL_SCALE));
    endcase
  endfunction

  // Monitor: one expected entry per rising edge, compared 1 time unit later.
  always @(posedge dclk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn = txn + 1;
      check("bar_out",   int'(bar_out),   e.bar);
      check("hold_out",  int'(hold_out),  e.hold);
      check("level_out", int'(level_out), e.lvl);
      check("clip_out",  int'(clip_out),  e.clip);
      check("state",     int'(dut.r_state), e.st);
      $display("txn %0d rst=%0b vld=%0b pk=%03h bar=%02h hold=%02h lvl=%0d clip=%0b",
               txn, rst, peak_valid, peak_in, bar_out, hold_out, level_out, clip_out);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, random activity, reset again.
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'($urandom_range(0, 1)), rand_peak());
    step(1'b1, 1'b1, rand_peak());
    step(1'b1, 1'b0, 0);

    // Full scale then a run of zero strobes: decay, hold, fall, clip timeout.
    step(1'b0, 1'b1, FULL_SCALE);
    for (int i = 0; i < 28; i++) step(1'b0, 1'b1, 0);

    // Mid-scale strobe from an empty bar, then a long gap with toggling input.
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 12'h400);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, int'($urandom_range(0, FULL_SCALE)));

    // Hold restart at the same level after 10 holding strobes.
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 12'h900);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 12'h900);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 0);

    // Reset during FALL on the same edge as a full-scale strobe.
    step(1'b0, 1'b1, FULL_SCALE);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 0);
    step(1'b1, 1'b1, FULL_SCALE);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);

    // Random soak with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), rand_peak());
    end

    @(negedge dclk);
    peak_valid = 1'b0;
    rst        = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge dclk);
    #2;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
